// File: rtl/pkg_audio.sv
// Shared types and constants for the audio tone path.
package pkg_audio;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } t_tone_st;

   localparam logic [8:0] GAIN_UNITY = 9'd256;
   localparam int         GAIN_SHIFT = 8;

   typedef logic signed [15:0] t_sample;

   // One click-free ramp step of the gain toward its target.
   function automatic logic [8:0] gain_step(input logic [8:0] gain, input logic [8:0] target);
      if (gain < target)
         return gain + 9'd1;
      else if (gain > target)
         return gain - 9'd1;
      else
         return gain;
   endfunction

endpackage

// File: rtl/gen_tone_nco_tick.sv
// Sample-rate strobe: one-cycle pulse every p_divider clocks, active-high synchronous reset.
module gen_tone_nco_tick #(
   parameter int p_divider = 1042
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_stop,
   output logic o_tick
);

   localparam int CNT_W = $clog2(p_divider);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(p_divider - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= '0;
         o_tick <= 1'b0;
      end else if (i_stop) begin
         o_tick <= 1'b0;
      end else if (cnt_q == '0) begin
         cnt_q  <= RELOAD;
         o_tick <= 1'b1;
      end else begin
         cnt_q  <= cnt_q - 1'b1;
         o_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/gen_tone_nco.sv
// Tone source: phase accumulator -> external cosine lookup -> ramped gain -> req/ack to the codec driver.
//
// state    | meaning
// ST_IDLE  | silent, phase held at 0, zero-valued samples keep the driver fed
// ST_RUN   | tone running, gain steps toward the clamped target each tick
// ST_DRAIN | enable dropped, gain steps down to 0 then returns to IDLE
module gen_tone_nco
   import pkg_audio::*;
#(
   parameter int p_divider = 1042,
   parameter int p_phase_w = 16,
   parameter int p_dat_w   = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic [p_phase_w-1:0]        i_tune,
   input  logic [8:0]                  i_amp,
   output logic [p_phase_w-1:0]        o_phase,
   input  logic signed [p_dat_w-1:0]   i_cos,
   output logic signed [p_dat_w-1:0]   o_dat,
   output logic                        o_req,
   input  logic                        i_ack,
   output logic                        o_busy,
   output logic [7:0]                  o_ovr_cnt
);

   logic tick_s;
   logic tick_rst;

   t_tone_st               st_q, st_d;
   logic [p_phase_w-1:0]   acc_q, acc_d;
   logic [8:0]             gain_q, gain_d;
   logic [8:0]             amp_tgt;
   logic [8:0]             gain_dec;

   logic                       v1_q, v2_q;
   logic signed [p_dat_w-1:0]  cos_q;
   logic signed [p_dat_w+8:0]  prod;
   logic signed [p_dat_w-1:0]  scaled;

   assign tick_rst = ~i_rst;

   gen_tone_nco_tick #(
      .p_divider (p_divider)
   ) u_tick (
      .i_clk  (i_clk),
      .i_rst  (tick_rst),
      .i_stop (1'b0),
      .o_tick (tick_s)
   );

   assign amp_tgt  = (i_amp > GAIN_UNITY) ? GAIN_UNITY : i_amp;
   assign gain_dec = (gain_q == 9'd0) ? 9'd0 : gain_q - 9'd1;

   always_comb begin
      st_d   = st_q;
      gain_d = gain_q;
      acc_d  = acc_q;
      if (i_en) begin
         st_d   = ST_RUN;
         gain_d = gain_step(gain_q, amp_tgt);
         acc_d  = acc_q + i_tune;
      end else begin
         case (st_q)
            ST_IDLE: begin
               gain_d = 9'd0;
               acc_d  = '0;
            end
            default: begin
               gain_d = gain_dec;
               // Zero the phase on the same edge that leaves DRAIN so the next tone starts at phase 0.
               if (gain_dec == 9'd0) begin
                  st_d  = ST_IDLE;
                  acc_d = '0;
               end else begin
                  st_d  = ST_DRAIN;
                  acc_d = acc_q + i_tune;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         st_q    <= ST_IDLE;
         gain_q  <= 9'd0;
         acc_q   <= '0;
         o_phase <= '0;
      end else if (tick_s) begin
         st_q    <= st_d;
         gain_q  <= gain_d;
         acc_q   <= acc_d;
         o_phase <= acc_q;
      end
   end

   assign o_busy = (st_q != ST_IDLE);

   // Gain is stable between ticks (p_divider >= 4), so it can feed the multiplier directly.
   assign prod   = cos_q * $signed({1'b0, gain_q});
   assign scaled = p_dat_w'(prod >>> GAIN_SHIFT);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         cos_q     <= '0;
         o_dat     <= '0;
         o_req     <= 1'b0;
         o_ovr_cnt <= 8'd0;
      end else begin
         v1_q <= tick_s;
         v2_q <= v1_q;
         if (v1_q)
            cos_q <= i_cos;
         if (v2_q) begin
            if (o_req && !i_ack) begin
               if (o_ovr_cnt != 8'hFF)
                  o_ovr_cnt <= o_ovr_cnt + 8'd1;
            end else begin
               o_dat <= scaled;
               o_req <= 1'b1;
            end
         end else if (i_ack) begin
            o_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gen_tone_nco.sv
// Directed bench for gen_tone_nco with an identity cosine lookup and a short sample period.
module tb_gen_tone_nco;

   localparam int DIV = 8;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_en;
   logic [15:0]       i_tune;
   logic [8:0]        i_amp;
   logic [15:0]       o_phase;
   logic signed [15:0] i_cos;
   logic signed [15:0] o_dat;
   logic              o_req;
   logic              i_ack;
   logic              o_busy;
   logic [7:0]        o_ovr_cnt;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   assign i_cos = $signed(o_phase);

   gen_tone_nco #(
      .p_divider (DIV),
      .p_phase_w (16),
      .p_dat_w   (16)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_tune    (i_tune),
      .i_amp     (i_amp),
      .o_phase   (o_phase),
      .i_cos     (i_cos),
      .o_dat     (o_dat),
      .o_req     (o_req),
      .i_ack     (i_ack),
      .o_busy    (o_busy),
      .o_ovr_cnt (o_ovr_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (o_req !== 1'b1 && n < 4 * DIV) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_req_seen"}, 16'(o_req), 16'd1);
   endtask

   task automatic wait_tick(input string tag);
      int n = 0;
      while (dut.tick_s !== 1'b1 && n < 4 * DIV) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_tick_seen"}, 16'(dut.tick_s), 16'd1);
   endtask

   task automatic ack_pulse();
      i_ack = 1'b1;
      @(negedge i_clk);
      i_ack = 1'b0;
   endtask

   task automatic take_sample(input string tag, input logic [15:0] exp_dat, input logic [15:0] exp_ph);
      wait_req(tag);
      check({tag, "_dat"}, o_dat, exp_dat);
      check({tag, "_phase"}, o_phase, exp_ph);
      ack_pulse();
      check({tag, "_req_clr"}, 16'(o_req), 16'd0);
   endtask

   logic [15:0] up_dat [4] = '{16'd8, 16'd24, 16'd48, 16'd64};
   logic [15:0] up_ph  [4] = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000};
   logic [15:0] dn_dat [4] = '{16'd60, 16'd48, 16'd28, 16'd0};
   logic [15:0] dn_ph  [4] = '{16'h1400, 16'h1800, 16'h1C00, 16'h2000};

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst  = 1'b0;
      i_en   = 1'b1;
      i_tune = 16'h0400;
      i_amp  = 9'd4;
      i_ack  = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_req",   16'(o_req), 16'd0);
      check("rst_dat",   o_dat, 16'd0);
      check("rst_phase", o_phase, 16'd0);
      check("rst_busy",  16'(o_busy), 16'd0);
      check("rst_ovr",   16'(o_ovr_cnt), 16'd0);

      // First sample latency after release.
      i_rst = 1'b1;
      wait_tick("first");
      @(negedge i_clk);
      check("lat_t1_req", 16'(o_req), 16'd0);
      @(negedge i_clk);
      check("lat_t2_req", 16'(o_req), 16'd0);
      @(negedge i_clk);
      check("lat_t3_req", 16'(o_req), 16'd1);
      check("up0_dat", o_dat, 16'd0);
      check("up0_phase", o_phase, 16'h0000);
      ack_pulse();

      for (int i = 0; i < 4; i++) take_sample($sformatf("up%0d", i + 1), up_dat[i], up_ph[i]);
      check("run_busy", 16'(o_busy), 16'd1);

      i_en = 1'b0;
      for (int i = 0; i < 4; i++) take_sample($sformatf("dn%0d", i), dn_dat[i], dn_ph[i]);
      check("drained_busy", 16'(o_busy), 16'd0);
      take_sample("idle", 16'd0, 16'h0000);
      check("idle_busy", 16'(o_busy), 16'd0);

      // Half-cycle tuning at full scale: phase flips sign each sample while gain ramps to unity.
      i_amp  = 9'd256;
      i_tune = 16'h8000;
      i_en   = 1'b1;
      for (int k = 0; k <= 260; k++) begin
         int g;
         int v;
         logic [15:0] ev;
         g  = (k + 1 > 256) ? 256 : k + 1;
         v  = (k % 2 == 1) ? -128 * g : 0;
         ev = v[15:0];
         take_sample($sformatf("wrap%0d", k), ev, (k % 2 == 1) ? 16'h8000 : 16'h0000);
      end

      // Overrun: leave sample 261 unacknowledged across two more ticks.
      wait_req("ovr");
      check("ovr_first_dat", o_dat, 16'h8000);
      check("ovr_first_ph", o_phase, 16'h8000);
      repeat (18) @(negedge i_clk);
      check("ovr_cnt", 16'(o_ovr_cnt), 16'd2);
      check("ovr_frozen_dat", o_dat, 16'h8000);
      check("ovr_req_held", 16'(o_req), 16'd1);
      ack_pulse();
      check("ovr_ack_clr", 16'(o_req), 16'd0);

      // Ack coincident with the store edge of the next sample.
      wait_req("sim_old");
      check("sim_old_dat", o_dat, 16'h0000);
      wait_tick("sim");
      @(negedge i_clk);
      @(negedge i_clk);
      i_ack = 1'b1;
      @(negedge i_clk);
      i_ack = 1'b0;
      check("sim_req", 16'(o_req), 16'd1);
      check("sim_dat", o_dat, 16'h8000);
      check("sim_ovr", 16'(o_ovr_cnt), 16'd2);
      ack_pulse();

      // Reset while draining with a request pending.
      i_en = 1'b0;
      wait_req("mid");
      check("mid_busy", 16'(o_busy), 16'd1);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("mid_rst_req",  16'(o_req), 16'd0);
      check("mid_rst_busy", 16'(o_busy), 16'd0);
      check("mid_rst_ovr",  16'(o_ovr_cnt), 16'd0);
      check("mid_rst_dat",  o_dat, 16'd0);
      i_rst  = 1'b1;
      i_en   = 1'b1;
      i_amp  = 9'd4;
      i_tune = 16'h0400;
      take_sample("re0", 16'd0, 16'h0000);
      take_sample("re1", 16'd8, 16'h0400);
      check("re_busy", 16'(o_busy), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
